// File: rtl/two_four_decoder_pkg.sv
// rtl/two_four_decoder_pkg.sv - shared sizes and line index constants for the 2-to-4 decoder
package two_four_decoder_pkg;

    localparam int DEC_N = 4;
    localparam int IDX_W = 2;

    localparam int IDX_D0 = 0;
    localparam int IDX_D1 = 1;
    localparam int IDX_D2 = 2;
    localparam int IDX_D3 = 3;

    // One-hot line vector for a code, or all-zero when disabled.
    function automatic logic [DEC_N-1:0] decode_onehot(input logic [IDX_W-1:0] idx,
                                                       input logic en);
        logic [DEC_N-1:0] v;
        v = '0;
        if (en) begin
            v[idx] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/two_four_decoder_if.sv
// rtl/two_four_decoder_if.sv - decode, select-line and counter read-port signal bundle
interface two_four_decoder_if
    import two_four_decoder_pkg::*;
#(
    parameter int CNT_W = 8
);

    logic             en;
    logic             A;
    logic             B;
    logic             D0;
    logic             D1;
    logic             D2;
    logic             D3;
    logic             chg;
    logic [IDX_W-1:0] cnt_sel;
    logic             cnt_clr;
    logic [CNT_W-1:0] cnt_out;

    modport master (
        output en, A, B, cnt_sel, cnt_clr,
        input  D0, D1, D2, D3, chg, cnt_out
    );

    modport slave (
        input  en, A, B, cnt_sel, cnt_clr,
        output D0, D1, D2, D3, chg, cnt_out
    );

endinterface

// File: rtl/two_four_decoder_sat_counter.sv
// rtl/two_four_decoder_sat_counter.sv - saturating hit counter with synchronous clear
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);

    // Clear wins over a same-edge increment so a cleared counter reads 0, not 1.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/two_four_decoder.sv
// rtl/two_four_decoder.sv - registered 2-to-4 decoder with change strobe and per-line hit counters
module two_four_decoder
    import two_four_decoder_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input logic               clk,
    input logic               rst,
    two_four_decoder_if.slave bus
);

    logic [IDX_W-1:0] idx;
    logic [DEC_N-1:0] d_next;
    logic [DEC_N-1:0] d_q;
    logic             chg_q;
    logic [CNT_W-1:0] cnt [DEC_N];

    assign idx    = {bus.A, bus.B};
    assign d_next = decode_onehot(idx, bus.en);

    // chg compares against the vector currently on the lines, so en toggles count too.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_q   <= '0;
            chg_q <= 1'b0;
        end else begin
            d_q   <= d_next;
            chg_q <= (d_next != d_q);
        end
    end

    for (genvar i = 0; i < DEC_N; i++) begin : g_cnt
        sat_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk (clk),
            .rst (rst),
            .clr (bus.cnt_clr),
            .inc (d_next[i]),
            .q   (cnt[i])
        );
    end

    assign bus.D0      = d_q[IDX_D0];
    assign bus.D1      = d_q[IDX_D1];
    assign bus.D2      = d_q[IDX_D2];
    assign bus.D3      = d_q[IDX_D3];
    assign bus.chg     = chg_q;
    assign bus.cnt_out = cnt[bus.cnt_sel];

endmodule

// File: tb/tb_two_four_decoder.sv
// tb/tb_two_four_decoder.sv - scoreboard bench for two_four_decoder (CNT_W=8 and CNT_W=2 instances)
module tb_two_four_decoder;

    typedef struct {
        int         id;
        logic [3:0] d;
        logic       chg;
        logic       chk_a;
        logic [7:0] ca;
        logic       chk_b;
        logic [1:0] cb;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   step_id = 0;
    exp_t expq[$];

    two_four_decoder_if #(.CNT_W(8)) bus_a ();
    two_four_decoder_if #(.CNT_W(2)) bus_b ();

    two_four_decoder #(.CNT_W(8)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
    two_four_decoder #(.CNT_W(2)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

    always #5 clk = ~clk;

    task automatic step(input logic r, input logic en, input logic [1:0] ab,
                        input logic clr, input logic [1:0] sel,
                        input logic [3:0] d, input logic chg,
                        input logic chk_a, input logic [7:0] ca,
                        input logic chk_b, input logic [1:0] cb);
        exp_t e;
        @(negedge clk);
        rst = r;
        bus_a.en = en; bus_a.A = ab[1]; bus_a.B = ab[0]; bus_a.cnt_clr = clr; bus_a.cnt_sel = sel;
        bus_b.en = en; bus_b.A = ab[1]; bus_b.B = ab[0]; bus_b.cnt_clr = clr; bus_b.cnt_sel = sel;
        step_id++;
        e.id = step_id; e.d = d; e.chg = chg;
        e.chk_a = chk_a; e.ca = ca; e.chk_b = chk_b; e.cb = cb;
        expq.push_back(e);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                exp_t e;
                logic [3:0] da, db;
                e  = expq.pop_front();
                da = {bus_a.D3, bus_a.D2, bus_a.D1, bus_a.D0};
                db = {bus_b.D3, bus_b.D2, bus_b.D1, bus_b.D0};
                checks++;
                if (da !== e.d) begin
                    errors++;
                    $display("FAIL d_a step %0d got %b want %b", e.id, da, e.d);
                end
                checks++;
                if (bus_a.chg !== e.chg) begin
                    errors++;
                    $display("FAIL chg_a step %0d got %b want %b", e.id, bus_a.chg, e.chg);
                end
                checks++;
                if (db !== e.d) begin
                    errors++;
                    $display("FAIL d_b step %0d got %b want %b", e.id, db, e.d);
                end
                checks++;
                if (bus_b.chg !== e.chg) begin
                    errors++;
                    $display("FAIL chg_b step %0d got %b want %b", e.id, bus_b.chg, e.chg);
                end
                if (e.chk_a) begin
                    checks++;
                    if (bus_a.cnt_out !== e.ca) begin
                        errors++;
                        $display("FAIL cnt_a step %0d got %0d want %0d", e.id, bus_a.cnt_out, e.ca);
                    end
                end
                if (e.chk_b) begin
                    checks++;
                    if (bus_b.cnt_out !== e.cb) begin
                        errors++;
                        $display("FAIL cnt_b step %0d got %0d want %0d", e.id, bus_b.cnt_out, e.cb);
                    end
                end
            end
        end
    end

    initial begin
        bus_a.en = 1'b1; bus_a.A = 1'b1; bus_a.B = 1'b1; bus_a.cnt_clr = 1'b0; bus_a.cnt_sel = 2'd0;
        bus_b.en = 1'b1; bus_b.A = 1'b1; bus_b.B = 1'b1; bus_b.cnt_clr = 1'b0; bus_b.cnt_sel = 2'd0;

        // reset with en=1, AB=11, reading every counter
        step(1, 1, 2'b11, 0, 2'd0, 4'b0000, 0, 1, 8'd0, 1, 2'd0);
        step(1, 1, 2'b11, 0, 2'd1, 4'b0000, 0, 1, 8'd0, 1, 2'd0);
        step(1, 1, 2'b11, 0, 2'd2, 4'b0000, 0, 1, 8'd0, 1, 2'd0);
        step(1, 1, 2'b11, 0, 2'd3, 4'b0000, 0, 1, 8'd0, 1, 2'd0);
        // sweep
        step(0, 1, 2'b00, 0, 2'd0, 4'b0001, 1, 1, 8'd1, 1, 2'd1);
        step(0, 1, 2'b01, 0, 2'd1, 4'b0010, 1, 1, 8'd1, 1, 2'd1);
        step(0, 1, 2'b10, 0, 2'd2, 4'b0100, 1, 1, 8'd1, 1, 2'd1);
        step(0, 1, 2'b11, 0, 2'd3, 4'b1000, 1, 1, 8'd1, 1, 2'd1);
        // clear while disabled, then hold AB=10 and drop en
        step(0, 0, 2'b11, 1, 2'd2, 4'b0000, 1, 1, 8'd0, 1, 2'd0);
        step(0, 1, 2'b10, 0, 2'd2, 4'b0100, 1, 1, 8'd1, 0, 2'd0);
        step(0, 1, 2'b10, 0, 2'd2, 4'b0100, 0, 1, 8'd2, 0, 2'd0);
        step(0, 1, 2'b10, 0, 2'd2, 4'b0100, 0, 1, 8'd3, 0, 2'd0);
        step(0, 0, 2'b10, 0, 2'd2, 4'b0000, 1, 1, 8'd3, 0, 2'd0);
        step(0, 0, 2'b10, 0, 2'd0, 4'b0000, 0, 1, 8'd0, 1, 2'd0);
        // clear priority over increment
        step(0, 1, 2'b11, 1, 2'd3, 4'b1000, 1, 1, 8'd0, 1, 2'd0);
        step(0, 1, 2'b11, 0, 2'd3, 4'b1000, 0, 1, 8'd1, 1, 2'd1);
        step(0, 1, 2'b11, 0, 2'd3, 4'b1000, 0, 1, 8'd2, 1, 2'd2);
        step(0, 1, 2'b11, 0, 2'd3, 4'b1000, 0, 1, 8'd3, 1, 2'd3);
        step(0, 1, 2'b11, 0, 2'd3, 4'b1000, 0, 1, 8'd4, 1, 2'd3);
        step(0, 1, 2'b11, 0, 2'd3, 4'b1000, 0, 1, 8'd5, 1, 2'd3);
        // reset mid-run, then first edge after release
        step(1, 1, 2'b11, 0, 2'd3, 4'b0000, 0, 1, 8'd0, 1, 2'd0);
        step(0, 1, 2'b11, 0, 2'd3, 4'b1000, 1, 1, 8'd1, 1, 2'd1);
        // saturation of the 2-bit instance on line 1
        step(0, 0, 2'b01, 1, 2'd1, 4'b0000, 1, 1, 8'd0, 1, 2'd0);
        step(0, 1, 2'b01, 0, 2'd1, 4'b0010, 1, 1, 8'd1, 1, 2'd1);
        step(0, 1, 2'b01, 0, 2'd1, 4'b0010, 0, 1, 8'd2, 1, 2'd2);
        step(0, 1, 2'b01, 0, 2'd1, 4'b0010, 0, 1, 8'd3, 1, 2'd3);
        step(0, 1, 2'b01, 0, 2'd1, 4'b0010, 0, 1, 8'd4, 1, 2'd3);
        step(0, 1, 2'b01, 0, 2'd1, 4'b0010, 0, 1, 8'd5, 1, 2'd3);
        step(0, 1, 2'b01, 0, 2'd1, 4'b0010, 0, 1, 8'd6, 1, 2'd3);
        step(0, 0, 2'b01, 0, 2'd1, 4'b0000, 1, 1, 8'd6, 1, 2'd3);
        // cnt_sel alone moves the read mux
        step(0, 0, 2'b01, 0, 2'd0, 4'b0000, 0, 1, 8'd0, 1, 2'd0);

        for (int i = 0; i < 10 && expq.size() > 0; i++) @(negedge clk);
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", expq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
